fetch_stage_ctrl: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register, drives a valid/ready instruction-memory request port, accepts responses, and writes the IF/ID pipeline register (InstrD, PCD, PCPlus4D) that the decode stage consumes. It is the producer side of the IF/ID boundary. It handles variable memory latency, decode stalls and execute-stage redirects (taken branch/jump) without losing or duplicating instructions.

---
 rtl/fetch_stage_ctrl_if.sv | 25 ++
 rtl/fetch_stage_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem request FSM
// and IF/ID register. Define FETCH_BACK_TO_BACK_EN to overlap the next request with a delivery.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                StallD,
    input  logic                PCSrcE,
    input  logic [31:0]         PCTargetE,
    fetch_stage_ctrl_if.master  imem,
    output logic [31:0]         InstrD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D,
    output logic                ValidD
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic        req_valid_s;
    logic [31:0] req_addr_s;
    logic        deliver_s;
    logic [31:0] dlv_instr_s;
    logic [31:0] dlv_pc_s;
    logic [31:0] pcf_inc_s;
    logic [1:0]  unused_tgt_lsb_s;

    assign pcf_inc_s        = pcf_q + 32'd4;
    assign unused_tgt_lsb_s = PCTargetE[1:0];

    // Next-state, PC, hold buffer, request and IF/ID computation
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        inflight_pc_d = inflight_pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        instr_d       = instr_q;
        pcd_d         = pcd_q;
        pcplus4_d     = pcplus4_q;
        valid_d       = valid_q;
        req_valid_s   = 1'b0;
        req_addr_s    = pcf_q;
        deliver_s     = 1'b0;
        dlv_instr_s   = 32'h0000_0000;
        dlv_pc_s      = 32'h0000_0000;

        case (state_q)
            ST_REQ: begin
                req_valid_s = 1'b1;
                if (imem.imem_req_ready) begin
                    inflight_pc_d = pcf_q;
                    state_d       = PCSrcE ? ST_DROP : ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (PCSrcE) begin
                        state_d = ST_REQ;
                    end else if (!StallD) begin
                        deliver_s   = 1'b1;
                        dlv_instr_s = imem.imem_rsp_data;
                        dlv_pc_s    = inflight_pc_q;
                        pcf_d       = pcf_inc_s;
                        state_d     = ST_REQ;
`ifdef FETCH_BACK_TO_BACK_EN
                        // Overlap the next request with this delivery
                        req_valid_s = 1'b1;
                        req_addr_s  = pcf_inc_s;
                        if (imem.imem_req_ready) begin
                            inflight_pc_d = pcf_inc_s;
                            state_d       = ST_WAIT;
                        end else begin
                            state_d = ST_REQ;
                        end
`else
                        req_valid_s = 1'b0;
`endif
                    end else begin
                        hold_instr_d = imem.imem_rsp_data;
                        hold_pc_d    = inflight_pc_q;
                        pcf_d        = pcf_inc_s;
                        state_d      = ST_HOLD;
                    end
                end else if (PCSrcE) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (PCSrcE) begin
                    state_d = ST_REQ;
                end else if (!StallD) begin
                    deliver_s   = 1'b1;
                    dlv_instr_s = hold_instr_q;
                    dlv_pc_s    = hold_pc_q;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem.imem_rsp_valid) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (PCSrcE) begin
            pcf_d = {PCTargetE[31:2], 2'b00};
        end else begin
            pcf_d = pcf_d;
        end

        // Redirect beats delivery; an idle, unstalled cycle inserts a bubble
        if (PCSrcE || (!deliver_s && !StallD)) begin
            instr_d   = NOP_INSTR;
            pcd_d     = 32'h0000_0000;
            pcplus4_d = 32'h0000_0000;
            valid_d   = 1'b0;
        end else if (deliver_s) begin
            instr_d   = dlv_instr_s;
            pcd_d     = dlv_pc_s;
            pcplus4_d = dlv_pc_s + 32'd4;
            valid_d   = 1'b1;
        end else begin
            instr_d   = instr_q;
            pcd_d     = pcd_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end
    end

    // State, PC, hold buffer and IF/ID registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_REQ;
            pcf_q         <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
            hold_instr_q  <= 32'h0000_0000;
            hold_pc_q     <= 32'h0000_0000;
            instr_q       <= NOP_INSTR;
            pcd_q         <= 32'h0000_0000;
            pcplus4_q     <= 32'h0000_0000;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            inflight_pc_q <= inflight_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            instr_q       <= instr_d;
            pcd_q         <= pcd_d;
            pcplus4_q     <= pcplus4_d;
            valid_q       <= valid_d;
        end
    end

    assign imem.imem_req_valid = req_valid_s & rst;
    assign imem.imem_req_addr  = req_addr_s;
    assign InstrD              = instr_q;
    assign PCD                 = pcd_q;
    assign PCPlus4D            = pcplus4_q;
    assign ValidD              = valid_q;

endmodule
